// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and frame constants.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_LEN_HI  = 3'd3,
        ST_LEN_LO  = 3'd4,
        ST_DATA    = 3'd5,
        ST_CSUM    = 3'd6
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         LEN_W     = 16;

    // True when a received byte is the frame sync marker.
    function automatic logic is_sync(input logic [7:0] b);
        return (b == SYNC_BYTE);
    endfunction

endpackage

// File: rtl/program_loader_csum.sv
// loader_csum: 8-bit running-sum accumulator with clear, add and a zero test that
// includes the byte currently presented, so the final CSUM byte is judged on its accept edge.
module loader_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] din,
    output logic       next_zero
);

    logic [7:0] acc_r;
    logic [7:0] acc_next_s;

    // Sum including the incoming byte.
    always_comb begin
        acc_next_s = acc_r + din;
        next_zero  = (acc_next_s == 8'h00);
    end

    // Accumulator register; clear wins over add.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= 8'h00;
        end else if (clr) begin
            acc_r <= 8'h00;
        end else if (add) begin
            acc_r <= acc_next_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: decodes a framed byte stream and writes its payload into program memory.
// Defining PROGRAM_LOADER_CHECKSUM_EN adds the trailing CSUM byte check and makes err live.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int NBIT      = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [NBIT-1:0]      mem_addr,
    output logic [WORD_SIZE-1:0] mem_data,
    output logic                 mem_we,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 err
);

    localparam logic [NBIT-1:0]  ADDR_ONE = {{(NBIT-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

    loader_state_t state_r, state_s;

    // Only the address-high bits that survive truncation to NBIT are kept.
    logic [NBIT-WORD_SIZE-1:0] addr_hi_r, addr_hi_s;
    logic [WORD_SIZE-1:0]      len_hi_r, len_hi_s;
    logic [NBIT-1:0]           addr_cnt_r, addr_cnt_s;
    logic [LEN_W-1:0]          len_rem_r, len_rem_s;
    logic [LEN_W-1:0]          len_full_s;

    logic                 rx_ready_r, rx_ready_s;
    logic [NBIT-1:0]      mem_addr_r, mem_addr_s;
    logic [WORD_SIZE-1:0] mem_data_r, mem_data_s;
    logic                 mem_we_r, mem_we_s;
    logic                 cpu_hold_r, cpu_hold_s;
    logic                 done_r, done_s;
    logic                 accept_s;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic err_r, err_s;
    logic csum_clr_s, csum_add_s, csum_zero_s;

    // Every byte after sync, CSUM included, feeds the running sum.
    assign csum_clr_s = accept_s && (state_r == ST_IDLE) && is_sync(rx_data);
    assign csum_add_s = accept_s && (state_r != ST_IDLE);

    loader_csum u_csum (
        .clk       (clk),
        .rst       (rst),
        .clr       (csum_clr_s),
        .add       (csum_add_s),
        .din       (rx_data),
        .next_zero (csum_zero_s)
    );

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign accept_s   = rx_valid && rx_ready_r;
    assign len_full_s = {len_hi_r, rx_data};

    assign rx_ready = rx_ready_r;
    assign mem_addr = mem_addr_r;
    assign mem_data = mem_data_r;
    assign mem_we   = mem_we_r;
    assign cpu_hold = cpu_hold_r;
    assign done     = done_r;

    // Next-state and next-output decode; all outputs are registered below.
    always_comb begin
        state_s    = state_r;
        addr_hi_s  = addr_hi_r;
        len_hi_s   = len_hi_r;
        addr_cnt_s = addr_cnt_r;
        len_rem_s  = len_rem_r;
        rx_ready_s = 1'b1;
        mem_addr_s = mem_addr_r;
        mem_data_s = mem_data_r;
        mem_we_s   = 1'b0;
        cpu_hold_s = cpu_hold_r;
        done_s     = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        err_s      = 1'b0;
`endif
        if (accept_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (is_sync(rx_data)) begin
                        state_s    = ST_ADDR_HI;
                        cpu_hold_s = 1'b1;
                    end else begin
                        state_s    = ST_IDLE;
                    end
                end
                ST_ADDR_HI: begin
                    addr_hi_s = rx_data[NBIT-WORD_SIZE-1:0];
                    state_s   = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    addr_cnt_s = {addr_hi_r, rx_data};
                    state_s    = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    len_hi_s = rx_data;
                    state_s  = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_rem_s = len_full_s;
                    if (len_full_s != LEN_ZERO) begin
                        state_s = ST_DATA;
                    end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_s    = ST_CSUM;
`else
                        state_s    = ST_IDLE;
                        cpu_hold_s = 1'b0;
                        done_s     = 1'b1;
`endif
                    end
                end
                ST_DATA: begin
                    // Sync value is plain payload here; no mid-frame resync.
                    mem_we_s   = 1'b1;
                    mem_addr_s = addr_cnt_r;
                    mem_data_s = rx_data;
                    rx_ready_s = 1'b0;
                    addr_cnt_s = addr_cnt_r + ADDR_ONE;
                    len_rem_s  = len_rem_r - LEN_ONE;
                    if (len_rem_r == LEN_ONE) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_s    = ST_CSUM;
`else
                        state_s    = ST_IDLE;
                        cpu_hold_s = 1'b0;
                        done_s     = 1'b1;
`endif
                    end else begin
                        state_s = ST_DATA;
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    state_s    = ST_IDLE;
                    cpu_hold_s = 1'b0;
                    if (csum_zero_s) begin
                        done_s = 1'b1;
                    end else begin
                        err_s  = 1'b1;
                    end
                end
`endif
                default: begin
                    state_s    = ST_IDLE;
                    cpu_hold_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            addr_hi_r  <= {(NBIT-WORD_SIZE){1'b0}};
            len_hi_r   <= {WORD_SIZE{1'b0}};
            addr_cnt_r <= {NBIT{1'b0}};
            len_rem_r  <= LEN_ZERO;
            rx_ready_r <= 1'b0;
            mem_addr_r <= {NBIT{1'b0}};
            mem_data_r <= {WORD_SIZE{1'b0}};
            mem_we_r   <= 1'b0;
            cpu_hold_r <= 1'b0;
            done_r     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            err_r      <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            addr_hi_r  <= addr_hi_s;
            len_hi_r   <= len_hi_s;
            addr_cnt_r <= addr_cnt_s;
            len_rem_r  <= len_rem_s;
            rx_ready_r <= rx_ready_s;
            mem_addr_r <= mem_addr_s;
            mem_data_r <= mem_data_s;
            mem_we_r   <= mem_we_s;
            cpu_hold_r <= cpu_hold_s;
            done_r     <= done_s;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            err_r      <= err_s;
`endif
        end
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the CPU's program memory. It receives a framed byte stream over a valid/ready handshake, decodes the frame's load address and length, and writes the payload bytes into the program memory through a synchronous write port. It holds the CPU in reset while a frame is being loaded. It sits between the host/serial receive path and the program memory's write port.

## Interface
- `WORD_SIZE`, 8: data width of the stream and memory. Fixed at 8; any other value is unsupported.
- `NBIT`, 15: memory address width. The memory has 2**NBIT words.

- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `rx_data`  in  WORD_SIZE: incoming stream byte.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: loader accepts a byte on this edge when `rx_valid & rx_ready`.
- `mem_addr`  out  NBIT: write address.
- `mem_data`  out  WORD_SIZE: write data.
- `mem_we`  out  1: write strobe. Active high, one cycle per byte.
- `cpu_hold`  out  1: high from sync-byte accept until frame end.
- `done`  out  1: one-cycle pulse when a frame completes successfully.
- `err`  out  1: one-cycle pulse when a frame completes with a bad checksum.

## Operation
- Frame format: `0xA5` sync, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN data bytes, then CSUM (only when checksum is enabled).
- FSM states: IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA, CSUM.
- IDLE: accepted bytes other than `0xA5` are discarded. `0xA5` moves to ADDR_HI.
- ADDR_HI, ADDR_LO and LEN_HI, LEN_LO each advance one state per accepted byte.
- Address is the 16-bit {ADDR_HI, ADDR_LO} truncated to its low NBIT bits.
- Length is 16 bits, range 0..65535.
- DATA: each accepted byte is written to the current address. The address then increments modulo 2**NBIT (wraps 2**NBIT-1 → 0). The remaining count decrements.
- LEN=0: LEN_LO goes directly to CSUM, or ends the frame.
- In DATA, a byte equal to `0xA5` is payload. There is no resync mid-frame.
- Checksum: 8-bit running sum of every byte after sync, including CSUM. The frame is good when the sum ≡ 0 mod 256.
- Bad checksum: bytes already written stay written; `err` pulses.
- End of frame returns the FSM to IDLE and drops `cpu_hold`.
- Reset values: `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `cpu_hold`=0, `done`=0, `err`=0. FSM goes to IDLE, checksum accumulator is 0.
- Reset mid-frame: the frame is abandoned and no `done`/`err` is produced. A write already issued in that cycle is not cancelled. After reset, the loader waits for a new sync byte.

## Timing
- `rx_ready` is 1 in every cycle after reset, except the cycle in which `mem_we`=1.
- A data byte accepted at edge k makes `mem_we`, `mem_addr` and `mem_data` valid for cycle k+1 (registered). Consequently, back-to-back data bytes arrive at most every 2 cycles.
- `cpu_hold` rises in the cycle after the sync byte is accepted.
- `cpu_hold` falls in the same cycle that `done`/`err` is high.
- With checksum enabled: `done`/`err` is high in the cycle after CSUM is accepted.
- With checksum disabled: `done` is high in the same cycle as the final `mem_we`. For LEN=0, `done` is high in the cycle after LEN_LO is accepted.
- `done` and `err` are never high together.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined: the CSUM byte is expected and checked; `err` is live.
- Not defined: there is no CSUM state, the frame ends after the last data byte, and `err` is tied to 0.

## Structure
- Shared package holds:
  - the FSM state enum;
  - the `SYNC_BYTE` = 8'hA5 constant;
  - the `LEN_W` = 16 constant.
- Natural sub-module: `loader_csum`, an 8-bit accumulator with clear, add and zero-test.

## Test plan
- Good frame, checksum on: A5 02 00 00 03 11 22 33 95 → writes [0x0200]=11, [0x0201]=22, [0x0202]=33. `done` pulses once; `err`=0.
- Bad checksum: same frame with CSUM=94 → same three writes, then `err` pulses, `done`=0, `cpu_hold` falls.
- Address truncation and wrap: A5 FF FF 00 02 AA BB + csum → writes [0x7FFF]=AA, [0x0000]=BB.
- Noise and payload sync: bytes 00 13 before A5 are ignored. A payload byte A5 is written, not treated as resync.
- LEN=0: A5 12 34 00 00 BA → no `mem_we`; `done` pulses.
- Reset mid-frame: `rst` asserted after two data bytes → all outputs 0 next cycle, no `done`/`err`. A following good frame loads correctly.
